// File: rtl/led_scan_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : led_scan_pkg
//  Description : Shared types, defaults and helpers for the LED scan monitor.
//  Revision    : 1.0 - initial release
// ============================================================================
package led_scan_pkg;

    localparam int C_LED_W     = 8;
    localparam int C_DEF_CNT_W = 26;
    localparam int C_DEF_UNIT  = 1000000;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        TRACK = 1'b1
    } state_t;

    // Active-low segment patterns {g,f,e,d,c,b,a} for hex digits 0-F
    localparam logic [6:0] C_SEG_LUT [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    function automatic logic is_onehot(input logic [C_LED_W-1:0] v);
        return (v != '0) && ((v & (v - 8'd1)) == '0);
    endfunction

    function automatic logic [2:0] onehot_idx(input logic [C_LED_W-1:0] v);
        logic [2:0] idx;
        idx = '0;
        for (int i = 0; i < C_LED_W; i++) begin
            if (v[i]) idx = 3'(i);
        end
        return idx;
    endfunction

endpackage : led_scan_pkg
`default_nettype wire

// File: rtl/led_scan_monitor_if.sv
`default_nettype none
// ============================================================================
//  Module      : led_scan_monitor_if
//  Description : Observed LED bus plus the monitor's measurement outputs.
//  Revision    : 1.0 - initial release
// ============================================================================
interface led_scan_monitor_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 26
) ();

    logic [WIDTH-1:0] LED_IN;
    logic [2:0]       POS;
    logic             DIR;
    logic [CNT_W-1:0] PERIOD;
    logic [3:0]       MILLIONS;
    logic             VALID;
    logic             ERR;
    logic [6:0]       HEX0;

    modport master (
        output LED_IN,
        input  POS, DIR, PERIOD, MILLIONS, VALID, ERR, HEX0
    );

    modport slave (
        input  LED_IN,
        output POS, DIR, PERIOD, MILLIONS, VALID, ERR, HEX0
    );

endinterface : led_scan_monitor_if
`default_nettype wire

// File: rtl/led_period_div.sv
`default_nettype none
// ============================================================================
//  Module      : led_period_div
//  Description : Iterative rounding divider, q = min(15, round(period/UNIT)).
//  Revision    : 1.0 - initial release
// ============================================================================
module led_period_div #(
    parameter int CNT_W = 26,
    parameter int UNIT  = 1000000
) (
    input  wire              clk,
    input  wire              rst_n,
    input  wire              i_start,
    input  wire              i_abort,
    input  wire  [CNT_W-1:0] i_period,
    output logic [3:0]       o_q,
    output logic             o_valid
);

    localparam logic [CNT_W:0] C_UNIT = (CNT_W+1)'(UNIT);
    localparam logic [CNT_W:0] C_HALF = (CNT_W+1)'(UNIT / 2);

    logic [CNT_W:0] r_rem;
    logic [3:0]     r_q;
    logic           r_busy;

    // Rounding comes from pre-biasing the dividend by half a unit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rem   <= '0;
            r_q     <= '0;
            r_busy  <= 1'b0;
            o_q     <= '0;
            o_valid <= 1'b0;
        end else if (i_abort) begin
            r_busy  <= 1'b0;
            o_valid <= 1'b0;
        end else if (i_start) begin
            r_rem  <= {1'b0, i_period} + C_HALF;
            r_q    <= '0;
            r_busy <= 1'b1;
        end else if (r_busy) begin
            if ((r_rem >= C_UNIT) && (r_q != 4'd15)) begin
                r_rem <= r_rem - C_UNIT;
                r_q   <= r_q + 4'd1;
            end else begin
                o_q     <= r_q;
                o_valid <= 1'b1;
                r_busy  <= 1'b0;
            end
        end
    end

endmodule : led_period_div
`default_nettype wire

// File: rtl/led_scan_monitor.sv
`default_nettype none
// ============================================================================
//  Module      : led_scan_monitor
//  Description : Tracks a bouncing one-hot LED scanner, measures its step
//                interval and shows the rounded speed level on a 7-seg digit.
//  Revision    : 1.0 - initial release
// ============================================================================
module led_scan_monitor
    import led_scan_pkg::*;
#(
    parameter int WIDTH = C_LED_W,
    parameter int CNT_W = C_DEF_CNT_W,
    parameter int UNIT  = C_DEF_UNIT
) (
    input  wire               CLOCK_50,
    input  wire               KEY0,
    led_scan_monitor_if.slave bus
);

    state_t           r_state, w_state_nxt;
    logic [WIDTH-1:0] r_s1, r_s2;
    logic [WIDTH-1:0] r_prev, w_prev_nxt;
    logic [2:0]       r_pos, w_pos_nxt;
    logic             r_dir, w_dir_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic [CNT_W-1:0] r_period, w_period_nxt;
    logic             r_primed, w_primed_nxt;
    logic             r_err, w_err_nxt;
    logic             w_start, w_abort;

    logic             w_onehot, w_up, w_dn;
    logic [WIDTH-1:0] w_prev_shl, w_prev_shr;
    logic [CNT_W-1:0] w_cnt_inc;
    logic [3:0]       w_millions;
    logic             w_valid;

    assign w_prev_shl = r_prev << 1;
    assign w_prev_shr = r_prev >> 1;
    assign w_onehot   = is_onehot(r_s2);
    // A shifted-out end LED yields zero, so legality also requires one-hot
    assign w_up       = w_onehot && (r_s2 == w_prev_shl);
    assign w_dn       = w_onehot && (r_s2 == w_prev_shr);
    assign w_cnt_inc  = (r_cnt == '1) ? r_cnt : r_cnt + CNT_W'(1);

    always_ff @(posedge CLOCK_50 or negedge KEY0) begin
        if (!KEY0) begin
            r_s1 <= '0;
            r_s2 <= '0;
        end else begin
            r_s1 <= bus.LED_IN;
            r_s2 <= r_s1;
        end
    end

    always_ff @(posedge CLOCK_50 or negedge KEY0) begin
        if (!KEY0) r_state <= IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_prev_nxt   = r_prev;
        w_pos_nxt    = r_pos;
        w_dir_nxt    = r_dir;
        w_cnt_nxt    = r_cnt;
        w_period_nxt = r_period;
        w_primed_nxt = r_primed;
        w_err_nxt    = r_err;
        w_start      = 1'b0;
        w_abort      = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_onehot) begin
                    w_prev_nxt   = r_s2;
                    w_pos_nxt    = onehot_idx(r_s2);
                    w_cnt_nxt    = CNT_W'(1);
                    w_primed_nxt = 1'b0;
                    w_state_nxt  = TRACK;
                end
            end
            TRACK: begin
                w_cnt_nxt = w_cnt_inc;
                if (r_s2 == r_prev) begin
                    w_cnt_nxt = w_cnt_inc;
                end else if (w_up || w_dn) begin
                    w_pos_nxt    = onehot_idx(r_s2);
                    w_dir_nxt    = w_up;
                    w_prev_nxt   = r_s2;
                    w_cnt_nxt    = CNT_W'(1);
                    w_primed_nxt = 1'b1;
                    // The first interval after entering TRACK is partial
                    if (r_primed) begin
                        w_period_nxt = r_cnt;
                        w_start      = 1'b1;
                    end
                end else begin
                    w_err_nxt   = 1'b1;
                    w_abort     = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_50 or negedge KEY0) begin
        if (!KEY0) begin
            r_prev   <= '0;
            r_pos    <= '0;
            r_dir    <= 1'b0;
            r_cnt    <= '0;
            r_period <= '0;
            r_primed <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_prev   <= w_prev_nxt;
            r_pos    <= w_pos_nxt;
            r_dir    <= w_dir_nxt;
            r_cnt    <= w_cnt_nxt;
            r_period <= w_period_nxt;
            r_primed <= w_primed_nxt;
            r_err    <= w_err_nxt;
        end
    end

    led_period_div #(
        .CNT_W (CNT_W),
        .UNIT  (UNIT)
    ) u_div (
        .clk      (CLOCK_50),
        .rst_n    (KEY0),
        .i_start  (w_start),
        .i_abort  (w_abort),
        .i_period (r_cnt),
        .o_q      (w_millions),
        .o_valid  (w_valid)
    );

    assign bus.POS      = r_pos;
    assign bus.DIR      = r_dir;
    assign bus.PERIOD   = r_period;
    assign bus.MILLIONS = w_millions;
    assign bus.VALID    = w_valid;
    assign bus.ERR      = r_err;
    assign bus.HEX0     = C_SEG_LUT[w_millions];

endmodule : led_scan_monitor
`default_nettype wire

// File: tb/tb_led_scan_monitor.sv
`default_nettype none
// ============================================================================
//  Module      : tb_led_scan_monitor
//  Description : Directed, table-driven self-checking bench for led_scan_monitor.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_led_scan_monitor;

    localparam int C_CNT_W = 16;
    localparam int C_UNIT  = 10;

    logic clk;
    logic key0;
    int   total;
    int   bad;

    led_scan_monitor_if #(.WIDTH(8), .CNT_W(C_CNT_W)) bus ();

    led_scan_monitor #(
        .WIDTH (8),
        .CNT_W (C_CNT_W),
        .UNIT  (C_UNIT)
    ) dut (
        .CLOCK_50 (clk),
        .KEY0     (key0),
        .bus      (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  led;
        int          hold;
        logic [2:0]  pos;
        logic        dir;
        logic [15:0] period;
        logic [3:0]  mill;
        logic        valid;
        logic        err;
        logic [6:0]  hex;
    } vec_t;

    vec_t tbl [17];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [2:0] pos, input logic dir,
                             input logic [15:0] period, input logic [3:0] mill,
                             input logic valid, input logic err, input logic [6:0] hex);
        check({tag, "_pos"},    32'(bus.POS),      32'(pos));
        check({tag, "_dir"},    32'(bus.DIR),      32'(dir));
        check({tag, "_period"}, 32'(bus.PERIOD),   32'(period));
        check({tag, "_mill"},   32'(bus.MILLIONS), 32'(mill));
        check({tag, "_valid"},  32'(bus.VALID),    32'(valid));
        check({tag, "_err"},    32'(bus.ERR),      32'(err));
        check({tag, "_hex"},    32'(bus.HEX0),     32'(hex));
    endtask

    task automatic do_reset();
        key0       = 1'b0;
        bus.LED_IN = 8'h00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        key0 = 1'b1;
    endtask

    task automatic edges(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        total = 0;
        bad   = 0;

        tbl[0]  = '{8'h01,  50, 3'd0, 1'b0, 16'd0,   4'd0,  1'b0, 1'b0, 7'h40};
        tbl[1]  = '{8'h02,  50, 3'd1, 1'b1, 16'd0,   4'd0,  1'b0, 1'b0, 7'h40};
        tbl[2]  = '{8'h04,  50, 3'd2, 1'b1, 16'd50,  4'd5,  1'b1, 1'b0, 7'h12};
        tbl[3]  = '{8'h08,  50, 3'd3, 1'b1, 16'd50,  4'd5,  1'b1, 1'b0, 7'h12};
        tbl[4]  = '{8'h10,  35, 3'd4, 1'b1, 16'd50,  4'd5,  1'b1, 1'b0, 7'h12};
        tbl[5]  = '{8'h20,  35, 3'd5, 1'b1, 16'd35,  4'd4,  1'b1, 1'b0, 7'h19};
        tbl[6]  = '{8'h40,  35, 3'd6, 1'b1, 16'd35,  4'd4,  1'b1, 1'b0, 7'h19};
        tbl[7]  = '{8'h80,  35, 3'd7, 1'b1, 16'd35,  4'd4,  1'b1, 1'b0, 7'h19};
        tbl[8]  = '{8'h40,  35, 3'd6, 1'b0, 16'd35,  4'd4,  1'b1, 1'b0, 7'h19};
        tbl[9]  = '{8'h20,  20, 3'd5, 1'b0, 16'd35,  4'd4,  1'b1, 1'b0, 7'h19};
        tbl[10] = '{8'h10,  20, 3'd4, 1'b0, 16'd20,  4'd2,  1'b1, 1'b0, 7'h24};
        tbl[11] = '{8'h80,  10, 3'd7, 1'b0, 16'd20,  4'd2,  1'b0, 1'b1, 7'h24};
        tbl[12] = '{8'h40,  40, 3'd6, 1'b0, 16'd20,  4'd2,  1'b0, 1'b1, 7'h24};
        tbl[13] = '{8'h20,  40, 3'd5, 1'b0, 16'd40,  4'd4,  1'b1, 1'b1, 7'h19};
        tbl[14] = '{8'h40, 400, 3'd6, 1'b1, 16'd40,  4'd4,  1'b1, 1'b1, 7'h19};
        tbl[15] = '{8'h80,  60, 3'd7, 1'b1, 16'd400, 4'd15, 1'b1, 1'b1, 7'h0E};
        tbl[16] = '{8'h00,  20, 3'd7, 1'b1, 16'd400, 4'd15, 1'b0, 1'b1, 7'h0E};

        // Idle after reset with a dark bus
        do_reset();
        edges(100);
        check_all("idle", 3'd0, 1'b0, 16'd0, 4'd0, 1'b0, 1'b0, 7'h40);

        // Main table: each LED value held for 'hold' rising edges
        for (int i = 0; i < 17; i++) begin
            @(negedge clk);
            bus.LED_IN = tbl[i].led;
            edges(tbl[i].hold);
            check_all($sformatf("row%0d", i), tbl[i].pos, tbl[i].dir, tbl[i].period,
                      tbl[i].mill, tbl[i].valid, tbl[i].err, tbl[i].hex);
        end

        // Two-edge synchronizer latency on a step and on an illegal jump
        do_reset();
        bus.LED_IN = 8'h01;
        edges(10);
        @(negedge clk);
        bus.LED_IN = 8'h02;
        edges(2);
        check("lat_pos_before", 32'(bus.POS), 32'd0);
        edges(1);
        check("lat_pos_after", 32'(bus.POS), 32'd1);
        check("lat_dir_after", 32'(bus.DIR), 32'd1);
        edges(10);
        @(negedge clk);
        bus.LED_IN = 8'h10;
        edges(2);
        check("lat_err_before", 32'(bus.ERR), 32'd0);
        edges(1);
        check("lat_err_after", 32'(bus.ERR), 32'd1);
        check("lat_valid_after", 32'(bus.VALID), 32'd0);

        // Asynchronous reset while the divider is busy
        do_reset();
        bus.LED_IN = 8'h01;
        edges(20);
        @(negedge clk);
        bus.LED_IN = 8'h02;
        edges(20);
        @(negedge clk);
        bus.LED_IN = 8'h04;
        edges(5);
        check("busy_period", 32'(bus.PERIOD), 32'd20);
        check("busy_valid", 32'(bus.VALID), 32'd0);
        check("busy_pos", 32'(bus.POS), 32'd2);
        key0 = 1'b0;
        #1;
        check_all("arst", 3'd0, 1'b0, 16'd0, 4'd0, 1'b0, 1'b0, 7'h40);
        bus.LED_IN = 8'h00;
        @(negedge clk);
        key0 = 1'b1;
        edges(30);
        check_all("post_arst", 3'd0, 1'b0, 16'd0, 4'd0, 1'b0, 1'b0, 7'h40);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_led_scan_monitor
`default_nettype wire

// File: doc/led_scan_monitor.md
# led_scan_monitor

Observer for the 8-bit bouncing-LED scanner bus. Consumes the one-hot LED pattern, tracks position and direction, measures the step interval in clock cycles, converts it to a rounded speed level in units of `UNIT` cycles, and shows that level on a seven-segment digit. Sits beside the scanner as its reader and self-check.

## Interface

Parameters:
- `WIDTH`, 8, LED bus width; fixed at 8 for this block.
- `CNT_W`, 26, interval counter and `PERIOD` width.
- `UNIT`, 1000000, cycles per speed level; the bench uses small values such as 10.

Ports:
- `CLOCK_50`, in, 1, the only clock.
- `KEY0`, in, 1, asynchronous active-low reset.
- `LED_IN`, in, 8, observed scanner LED bus.
- `POS`, out, 3, index of the lit LED.
- `DIR`, out, 1, 1 = last step toward the MSB, 0 = toward the LSB.
- `PERIOD`, out, `CNT_W`, cycles between the last two steps.
- `MILLIONS`, out, 4, round(`PERIOD`/`UNIT`), saturating at 15.
- `VALID`, out, 1, `MILLIONS` holds a completed measurement.
- `ERR`, out, 1, sticky protocol error.
- `HEX0`, out, 7, active-low segments {g..a} showing the hex digit of `MILLIONS`.

## Operation

Reset: all registers clear. `POS`=0, `DIR`=0, `PERIOD`=0, `MILLIONS`=0, `VALID`=0, `ERR`=0, `HEX0`=7'b1000000. FSM goes to IDLE.

Input path:
- `LED_IN` passes through a 2-flop synchronizer (`s1`, `s2`).
- `prev` holds the last accepted `s2` value.

FSM:
- **IDLE**
  - Waits for `s2` to be one-hot; zero or other non-one-hot values are ignored, no error.
  - On one-hot: `prev`<=`s2`, `POS`<=index, `cnt`<=1, `primed`<=0, go to TRACK.
- **TRACK**
  - `cnt` increments every cycle and saturates at 2^`CNT_W`−1.
  - If `s2`==`prev`: no action.
  - Legal step (`s2`==`prev`<<1 or `s2`==`prev`>>1):
    - update `POS`; `DIR`<=(`s2`==`prev`<<1); `prev`<=`s2`; `cnt`<=1.
    - If `primed`: `PERIOD`<=`cnt` and pulse `start` to the divider.
    - `primed`<=1 in all cases, because the first interval after entering TRACK is partial and is discarded.
  - Any other change (not one-hot, zero, or a jump of more than one position):
    - `ERR`<=1, `VALID`<=0, go to IDLE.
    - Any division in progress is aborted.

Divider (`led_period_div`):
- On `start`: `rem`<=`PERIOD`+`UNIT`/2 (`CNT_W`+1 bits), `q`<=0, busy.
- Each busy cycle:
  - if `rem`>=`UNIT` and `q`<15: `rem`-=`UNIT`, `q`++;
  - else `MILLIONS`<=`q`, `VALID`<=1, idle.
- A `start` while busy restarts from the new `PERIOD`. `MILLIONS` keeps its old value until the restarted division completes.

Other rules:
- `ERR` clears only on reset. New steps after recovery through IDLE are measured normally; `ERR` stays 1.
- `HEX0` is a combinational decode of `MILLIONS` (0-F, standard active-low patterns).
- Asserting `KEY0` mid-operation clears everything immediately, including synchronizer flops and divider state.

## Timing

- `LED_IN` change sampled at edge k:
  - `s2` holds the new value after edge k+1.
  - `POS`, `DIR`, `PERIOD` update at edge k+2.
- Divider loads at the same edge as `PERIOD`. `MILLIONS`/`VALID` update q+1 edges later, so at most 16.
- `PERIOD` equals the number of rising edges between consecutive accepted steps. A scanner stepping every N cycles gives `PERIOD`=N exactly.
- Intervals of 16 cycles or fewer with `MILLIONS`≥15 can restart the divider before it completes. The result then reflects the latest `PERIOD` only.
- Saturation: `cnt` stops at its maximum. `MILLIONS` is capped at 15.

## Structure

- Package `led_scan_pkg`:
  - FSM state enum (IDLE, TRACK);
  - the seven-segment constant array for 0-F;
  - default `UNIT` and `CNT_W`.
- Sub-module `led_period_div`: the iterative rounding divider, with start/busy and `q` output.
- Top level holds the synchronizer, FSM, counter, and `HEX0` decode.

## Test plan

- Reset then release with `LED_IN`=0 for 100 cycles -> FSM stays in IDLE; all outputs at reset values; `HEX0`=1000000.
- `UNIT`=10; drive 0x01→0x02→0x04→0x08, each value held 50 cycles -> `PERIOD`=50, `MILLIONS`=5, `HEX0`=0010010, `VALID`=1, `DIR`=1, `POS`=3.
- Bounce at the ends: 0x40→0x80→0x40, holding 35 cycles -> `DIR` goes 1 then 0, `POS` 7→6, `MILLIONS`=4 (35+5=40, rounds to 4).
- Illegal jump 0x04→0x20 -> `ERR`=1 and `VALID`=0 two edges later; a subsequent legal sequence re-measures with `ERR` still 1.
- Saturation: `UNIT`=10, interval 400 -> `MILLIONS`=15, `HEX0`=0001110.
- Assert `KEY0` while the divider is busy -> all outputs return to reset values asynchronously; no `VALID` after release.
